ddr2_cmd_sched: RTL and testbench



---
 rtl/ddr2_cmd_sched_pkg.sv | 55 +++++
 rtl/ddr2_cmd_sched_if.sv | 15 +
 rtl/ddr2_bank_tracker.sv | 70 +++++++
 rtl/ddr2_cmd_sched.sv | 208 ++++++++++++++++++++
 tb/tb_ddr2_cmd_sched.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ddr2_cmd_sched_pkg.sv
// ddr2_sched_pkg: shared types and constants for the DDR2 open-page command
// scheduler. It holds the timing parameters in controller clock cycles, the
// request address field layout, the {ras_n,cas_n,we_n} command encodings,
// the packed command-bus struct and the FSM state enum.
package ddr2_sched_pkg;

  // Timing, in controller clock cycles.
  localparam int T_RCD  = 4;
  localparam int T_RP   = 4;
  localparam int T_RAS  = 12;
  localparam int T_RFC  = 51;
  localparam int T_REFI = 1560;

  // Request address layout: {rank[27], bank[26:24], row[23:10], col[9:0]}.
  localparam int ADDR_W    = 28;
  localparam int ROW_W     = 14;
  localparam int COL_W     = 10;
  localparam int BANK_W    = 3;
  localparam int IDX_W     = 4;
  localparam int NUM_BANKS = 16;
  localparam int COL_LSB   = 0;
  localparam int ROW_LSB   = 10;
  localparam int BANK_LSB  = 24;
  localparam int RANK_BIT  = 27;

  typedef logic [IDX_W-1:0] bank_idx_t;   // {rank, bank}
  typedef logic [ROW_W-1:0] row_t;

  // {ras_n, cas_n, we_n}
  typedef logic [2:0] cmd_t;
  localparam cmd_t CMD_NOP = 3'b111;
  localparam cmd_t CMD_ACT = 3'b011;
  localparam cmd_t CMD_RD  = 3'b101;
  localparam cmd_t CMD_WR  = 3'b100;
  localparam cmd_t CMD_PRE = 3'b010;
  localparam cmd_t CMD_REF = 3'b001;

  typedef struct packed {
    logic [1:0]        cs_n;
    cmd_t              cmd;
    logic [BANK_W-1:0] ba;
    logic [ROW_W-1:0]  addr;
  } cmd_bus_t;

  localparam cmd_bus_t BUS_DESELECT = {2'b11, CMD_NOP, 3'b000, 14'h0000};
  // PRE-ALL has A10 set and selects both ranks.
  localparam cmd_bus_t BUS_PREALL   = {2'b00, CMD_PRE, 3'b000, 14'h0400};
  localparam cmd_bus_t BUS_REF      = {2'b00, CMD_REF, 3'b000, 14'h0000};

  typedef enum logic [3:0] {
    IDLE, PRE_WAIT_RAS, PRE, TRP_WAIT, ACT, TRCD_WAIT, RW,
    REF_PREALL, REF_TRP, REF, REF_TRFC
  } state_e;

endpackage

// File: rtl/ddr2_cmd_sched_if.sv
// ddr2_cmd_sched_if: request handshake between the controller front end
// (master) and the command scheduler (slave).
//   req_valid  request present
//   req_ready  request accepted when valid & ready
//   req_we     1 = write, 0 = read
//   req_addr   {rank, bank, row, col}
interface ddr2_cmd_sched_if;
  logic                              req_valid;
  logic                              req_ready;
  logic                              req_we;
  logic [ddr2_sched_pkg::ADDR_W-1:0] req_addr;

  modport master (output req_valid, output req_we, output req_addr, input req_ready);
  modport slave  (input req_valid, input req_we, input req_addr, output req_ready);
endinterface

// File: rtl/ddr2_bank_tracker.sv
// ddr2_bank_tracker: open-row table and tRAS down-counters for all 16
// rank x bank pairs.
//   lookup_idx_i/lookup_row_i -> hit_o, closed_o, conflict_o, ras_ok_o
//   open_i(open_idx_i, open_row_i)  mark bank open, restart its tRAS counter
//   close_i(close_idx_i)            mark one bank closed
//   close_all_i                     mark every bank closed
//   all_ras_ok_o                    every tRAS counter has expired
module ddr2_bank_tracker
  import ddr2_sched_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  bank_idx_t lookup_idx_i,
  input  row_t      lookup_row_i,
  output logic      hit_o,
  output logic      closed_o,
  output logic      conflict_o,
  output logic      ras_ok_o,
  input  logic      open_i,
  input  bank_idx_t open_idx_i,
  input  row_t      open_row_i,
  input  logic      close_i,
  input  bank_idx_t close_idx_i,
  input  logic      close_all_i,
  output logic      all_ras_ok_o
);
  localparam int RAS_W = $clog2(T_RAS);

  logic [NUM_BANKS-1:0] open_vec;
  logic [NUM_BANKS-1:0] ras_zero;
  row_t                 row_arr [NUM_BANKS];

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic             open_q;
    row_t             row_q;
    logic [RAS_W-1:0] ras_q;

    // open_i is strobed during the ACT cycle itself, so the counter is
    // loaded one short: it reads zero T_RAS-1 cycles after ACT and the
    // earliest PRE lands exactly T_RAS cycles after ACT.
    always_ff @(posedge clk) begin
      if (rst) begin
        open_q <= 1'b0;
        row_q  <= '0;
        ras_q  <= '0;
      end else if (open_i && open_idx_i == bank_idx_t'(gi)) begin
        open_q <= 1'b1;
        row_q  <= open_row_i;
        ras_q  <= RAS_W'(T_RAS - 2);
      end else begin
        if (close_all_i || (close_i && close_idx_i == bank_idx_t'(gi))) begin
          open_q <= 1'b0;
        end
        if (ras_q != '0) begin
          ras_q <= ras_q - 1'b1;
        end
      end
    end

    assign open_vec[gi] = open_q;
    assign row_arr[gi]  = row_q;
    assign ras_zero[gi] = (ras_q == '0);
  end

  assign closed_o     = ~open_vec[lookup_idx_i];
  assign hit_o        = open_vec[lookup_idx_i] & (row_arr[lookup_idx_i] == lookup_row_i);
  assign conflict_o   = open_vec[lookup_idx_i] & (row_arr[lookup_idx_i] != lookup_row_i);
  assign ras_ok_o     = ras_zero[lookup_idx_i];
  assign all_ras_ok_o = &ras_zero;
endmodule

// File: rtl/ddr2_cmd_sched.sv
// ddr2_cmd_sched: open-page DDR2 command scheduler. Accepts one read/write
// request at a time, issues PRE/ACT/RD/WR with tRP/tRCD/tRAS honoured, and
// inserts a PRE-ALL + REF sequence every T_REFI cycles.
//   clk, rst        controller clock, synchronous active-high reset
//   init_done       external init finished; scheduler inert while low
//   req             request handshake (slave side)
//   cs_n, ras_n, cas_n, we_n, ba, addr   registered SODIMM command pins
//   issue_valid/issue_we  pulse with each RD/WR and its direction
//   ref_busy        high from PRE-ALL through the end of tRFC
module ddr2_cmd_sched
  import ddr2_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                init_done,
  ddr2_cmd_sched_if.slave     req,
  output logic [1:0]          cs_n,
  output logic                ras_n,
  output logic                cas_n,
  output logic                we_n,
  output logic [BANK_W-1:0]   ba,
  output logic [ROW_W-1:0]    addr,
  output logic                issue_valid,
  output logic                issue_we,
  output logic                ref_busy
);
  localparam int WAIT_W = $clog2(T_RFC);
  localparam int REFI_W = $clog2(T_REFI);

  state_e              state_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic                req_we_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [REFI_W-1:0]   ref_timer_q;
  logic                ref_pend_q;
  cmd_bus_t            bus_q;
  logic                issue_valid_q;
  logic                issue_we_q;
  logic                ref_busy_q;

  logic [ADDR_W-1:0]   cur_addr;
  logic                cur_we;
  bank_idx_t           cur_idx;
  row_t                cur_row;
  logic [1:0]          cur_cs_n;
  cmd_bus_t            act_bus, pre_bus, rw_bus;
  logic                lk_hit, lk_closed, lk_conflict, lk_ras_ok, all_ras_ok;
  logic                accept;

  // In IDLE the request is classified straight off the interface so a hit
  // can issue on the very next cycle; afterwards the captured copy is used.
  assign cur_addr = (state_q == IDLE) ? req.req_addr : req_addr_q;
  assign cur_we   = (state_q == IDLE) ? req.req_we   : req_we_q;
  assign cur_idx  = {cur_addr[RANK_BIT], cur_addr[BANK_LSB +: BANK_W]};
  assign cur_row  = cur_addr[ROW_LSB +: ROW_W];
  assign cur_cs_n = cur_addr[RANK_BIT] ? 2'b01 : 2'b10;

  assign act_bus = {cur_cs_n, CMD_ACT, cur_addr[BANK_LSB +: BANK_W], cur_row};
  assign pre_bus = {cur_cs_n, CMD_PRE, cur_addr[BANK_LSB +: BANK_W], 14'h0000};
  assign rw_bus  = {cur_cs_n, (cur_we ? CMD_WR : CMD_RD), cur_addr[BANK_LSB +: BANK_W],
                    4'b0000, cur_addr[COL_LSB +: COL_W]};

  assign req.req_ready = (state_q == IDLE) & init_done & ~ref_pend_q;
  assign accept        = req.req_valid & req.req_ready;

  // Table updates follow the registered state, i.e. they take effect at the
  // end of the cycle in which the command is on the pins.
  ddr2_bank_tracker u_tracker (
    .clk          (clk),
    .rst          (rst),
    .lookup_idx_i (cur_idx),
    .lookup_row_i (cur_row),
    .hit_o        (lk_hit),
    .closed_o     (lk_closed),
    .conflict_o   (lk_conflict),
    .ras_ok_o     (lk_ras_ok),
    .open_i       (state_q == ACT),
    .open_idx_i   (cur_idx),
    .open_row_i   (cur_row),
    .close_i      (state_q == PRE),
    .close_idx_i  (cur_idx),
    .close_all_i  (state_q == REF_PREALL),
    .all_ras_ok_o (all_ras_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_addr_q    <= '0;
      req_we_q      <= 1'b0;
      wait_q        <= '0;
      ref_timer_q   <= '0;
      ref_pend_q    <= 1'b0;
      bus_q         <= BUS_DESELECT;
      issue_valid_q <= 1'b0;
      issue_we_q    <= 1'b0;
      ref_busy_q    <= 1'b0;
    end else begin
      bus_q         <= BUS_DESELECT;
      issue_valid_q <= 1'b0;
      issue_we_q    <= 1'b0;

      if (!init_done) begin
        ref_timer_q <= '0;
      end else if (ref_timer_q == REFI_W'(T_REFI - 1)) begin
        ref_timer_q <= '0;
        ref_pend_q  <= 1'b1;
      end else begin
        ref_timer_q <= ref_timer_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (init_done && ref_pend_q) begin
            if (all_ras_ok) begin
              state_q    <= REF_PREALL;
              bus_q      <= BUS_PREALL;
              ref_busy_q <= 1'b1;
            end
          end else if (accept) begin
            req_addr_q <= req.req_addr;
            req_we_q   <= req.req_we;
            if (lk_hit) begin
              state_q       <= RW;
              bus_q         <= rw_bus;
              issue_valid_q <= 1'b1;
              issue_we_q    <= cur_we;
            end else if (lk_closed) begin
              state_q <= ACT;
              bus_q   <= act_bus;
            end else if (lk_conflict && !lk_ras_ok) begin
              state_q <= PRE_WAIT_RAS;
            end else begin
              state_q <= PRE;
              bus_q   <= pre_bus;
            end
          end
        end
        PRE_WAIT_RAS: begin
          if (lk_ras_ok) begin
            state_q <= PRE;
            bus_q   <= pre_bus;
          end
        end
        PRE: begin
          state_q <= TRP_WAIT;
          wait_q  <= WAIT_W'(T_RP - 2);
        end
        TRP_WAIT: begin
          if (wait_q == '0) begin
            state_q <= ACT;
            bus_q   <= act_bus;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        ACT: begin
          state_q <= TRCD_WAIT;
          wait_q  <= WAIT_W'(T_RCD - 2);
        end
        TRCD_WAIT: begin
          if (wait_q == '0) begin
            state_q       <= RW;
            bus_q         <= rw_bus;
            issue_valid_q <= 1'b1;
            issue_we_q    <= cur_we;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        RW: begin
          state_q <= IDLE;
        end
        REF_PREALL: begin
          state_q <= REF_TRP;
          wait_q  <= WAIT_W'(T_RP - 2);
        end
        REF_TRP: begin
          if (wait_q == '0) begin
            state_q    <= REF;
            bus_q      <= BUS_REF;
            ref_pend_q <= 1'b0;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        REF: begin
          state_q <= REF_TRFC;
          wait_q  <= WAIT_W'(T_RFC - 2);
        end
        REF_TRFC: begin
          if (wait_q == '0) begin
            state_q    <= IDLE;
            ref_busy_q <= 1'b0;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {cs_n, ras_n, cas_n, we_n, ba, addr} = bus_q;
  assign issue_valid = issue_valid_q;
  assign issue_we    = issue_we_q;
  assign ref_busy    = ref_busy_q;
endmodule

// File: tb/tb_ddr2_cmd_sched.sv
// Scoreboard bench for ddr2_cmd_sched. Stimulus pushes the hand-computed
// command sequence (absolute cycle + pin values) for each request; a monitor
// pops and compares whenever a command appears on the pins.
module tb_ddr2_cmd_sched;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [1:0] R0 = 2'b10;
  localparam logic [1:0] R1 = 2'b01;

  typedef struct {
    string       name;
    int          cyc;
    logic [24:0] bus;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic [1:0]  cs_n;
  logic        ras_n, cas_n, we_n;
  logic [2:0]  ba;
  logic [13:0] addr;
  logic        issue_valid, issue_we, ref_busy;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  ddr2_cmd_sched_if req_if();

  ddr2_cmd_sched dut (
    .clk         (clk),
    .rst         (rst),
    .init_done   (init_done),
    .req         (req_if),
    .cs_n        (cs_n),
    .ras_n       (ras_n),
    .cas_n       (cas_n),
    .we_n        (we_n),
    .ba          (ba),
    .addr        (addr),
    .issue_valid (issue_valid),
    .issue_we    (issue_we),
    .ref_busy    (ref_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void expect_cmd(input string name, input int c, input logic [1:0] cs,
                                     input logic [2:0] cmd, input logic [2:0] b,
                                     input logic [13:0] a, input logic iv, input logic iwe,
                                     input logic rb);
    exp_t e;
    e.name = name;
    e.cyc  = c;
    e.bus  = {cs, cmd, b, a, iv, iwe, rb};
    exp_q.push_back(e);
  endfunction

  // Present a request and return the cycle in which it was accepted.
  task automatic send(input logic we, input logic [27:0] a, output int t);
    int n;
    n = 0;
    @(negedge clk);
    req_if.req_valid = 1'b1;
    req_if.req_we    = we;
    req_if.req_addr  = a;
    while (req_if.req_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (req_if.req_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: req_ready stayed %b, expected 1 for addr %h", req_if.req_ready, a);
    end
    t = cyc;
    @(posedge clk);
    #1;
    req_if.req_valid = 1'b0;
  endtask

  // Monitor: every non-DESELECT cycle must match the next expected command.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cs_n !== 2'b11 || issue_valid !== 1'b0) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_cmd: got cs_n=%b cmd=%b%b%b ba=%0d addr=%h at cycle %0d, expected none",
                   cs_n, ras_n, cas_n, we_n, ba, addr, cyc);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_cycle"}, cyc, e.cyc);
          check({e.name, "_pins"},
                {7'b0, cs_n, ras_n, cas_n, we_n, ba, addr, issue_valid, issue_we, ref_busy},
                {7'b0, e.bus});
          $display("cycle %0d %s cs_n=%b cmd=%b%b%b ba=%0d addr=%h iv=%b we=%b",
                   cyc, e.name, cs_n, ras_n, cas_n, we_n, ba, addr, issue_valid, issue_we);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int t, a1, a4, p, c0;
    rst = 1'b1;
    init_done = 1'b0;
    req_if.req_valid = 1'b0;
    req_if.req_we    = 1'b0;
    req_if.req_addr  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pins", {7'b0, cs_n, ras_n, cas_n, we_n, ba, addr, issue_valid, issue_we, ref_busy},
          {7'b0, 2'b11, 3'b111, 3'b000, 14'h0000, 3'b000});
    check("rst_ready", {31'b0, req_if.req_ready}, 32'd0);
    rst = 1'b0;

    // Inert while init_done is low, even with a request waiting.
    req_if.req_valid = 1'b1;
    req_if.req_addr  = 28'h0000400;
    repeat (5) @(negedge clk);
    check("noinit_ready", {31'b0, req_if.req_ready}, 32'd0);
    req_if.req_valid = 1'b0;

    @(negedge clk);
    init_done = 1'b1;
    c0 = cyc;

    // Closed bank: ACT at t+1, RD at t+5.
    send(1'b0, 28'h0000400, t);
    a1 = t + 1;
    expect_cmd("rd_closed_act", t + 1, R0, C_ACT, 3'd0, 14'd1, 1'b0, 1'b0, 1'b0);
    expect_cmd("rd_closed_rd",  t + 5, R0, C_RD,  3'd0, 14'd0, 1'b1, 1'b0, 1'b0);
    // Page hit: RD at t+1.
    send(1'b0, 28'h0000408, t);
    expect_cmd("rd_hit", t + 1, R0, C_RD, 3'd0, 14'd8, 1'b1, 1'b0, 1'b0);
    // Conflict shortly after ACT: PRE waits for tRAS.
    send(1'b1, 28'h0000805, t);
    p = (t + 1 > a1 + 12) ? t + 1 : a1 + 12;
    expect_cmd("wr_conf_pre", p,     R0, C_PRE, 3'd0, 14'd0, 1'b0, 1'b0, 1'b0);
    expect_cmd("wr_conf_act", p + 4, R0, C_ACT, 3'd0, 14'd2, 1'b0, 1'b0, 1'b0);
    expect_cmd("wr_conf_wr",  p + 8, R0, C_WR,  3'd0, 14'd5, 1'b1, 1'b1, 1'b0);
    // Rank1 bank7.
    send(1'b1, 28'h0F000FFF, t);
    a4 = t + 1;
    expect_cmd("wr_r1_act", t + 1, R1, C_ACT, 3'd7, 14'd3,     1'b0, 1'b0, 1'b0);
    expect_cmd("wr_r1_wr",  t + 5, R1, C_WR,  3'd7, 14'h03FF, 1'b1, 1'b1, 1'b0);
    // Rank0 bank0 still open on row 2.
    send(1'b0, 28'h0000810, t);
    expect_cmd("rd_r0_hit", t + 1, R0, C_RD, 3'd0, 14'h0010, 1'b1, 1'b0, 1'b0);
    send(1'b0, 28'h0F000C01, t);
    expect_cmd("rd_r1_hit", t + 1, R1, C_RD, 3'd7, 14'd1, 1'b1, 1'b0, 1'b0);
    // Rank1 bank7 conflict.
    send(1'b0, 28'h0F001002, t);
    p = (t + 1 > a4 + 12) ? t + 1 : a4 + 12;
    expect_cmd("rd_r1_pre", p,     R1, C_PRE, 3'd7, 14'd0, 1'b0, 1'b0, 1'b0);
    expect_cmd("rd_r1_act", p + 4, R1, C_ACT, 3'd7, 14'd4, 1'b0, 1'b0, 1'b0);
    expect_cmd("rd_r1_rd",  p + 8, R1, C_RD,  3'd7, 14'd2, 1'b1, 1'b0, 1'b0);

    // Refresh: pending after T_REFI counted cycles, PRE-ALL, REF 4 later.
    expect_cmd("prealll", c0 + 1561, 2'b00, C_PRE, 3'd0, 14'h0400, 1'b0, 1'b0, 1'b1);
    expect_cmd("ref",     c0 + 1565, 2'b00, C_REF, 3'd0, 14'h0000, 1'b0, 1'b0, 1'b1);
    while (cyc < c0 + 1590) @(negedge clk);
    check("trfc_busy",  {31'b0, ref_busy}, 32'd1);
    check("trfc_ready", {31'b0, req_if.req_ready}, 32'd0);
    // Previously open row now needs ACT; accept only after tRFC.
    send(1'b0, 28'h0000820, t);
    check("ref_accept_cycle", t, c0 + 1616);
    expect_cmd("post_ref_act", t + 1, R0, C_ACT, 3'd0, 14'd2,     1'b0, 1'b0, 1'b0);
    expect_cmd("post_ref_rd",  t + 5, R0, C_RD,  3'd0, 14'h0020, 1'b1, 1'b0, 1'b0);

    // Reset during TRCD_WAIT: DESELECT next cycle, RD never issued.
    send(1'b0, 28'h0A001400, t);
    expect_cmd("rst_act", t + 1, R1, C_ACT, 3'd2, 14'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    init_done = 1'b0;
    @(negedge clk);
    check("midrst_pins", {7'b0, cs_n, ras_n, cas_n, we_n, ba, addr, issue_valid, issue_we, ref_busy},
          {7'b0, 2'b11, 3'b111, 3'b000, 14'h0000, 3'b000});
    check("midrst_ready", {31'b0, req_if.req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    init_done = 1'b1;
    // Bank table was cleared: former hit now needs ACT.
    send(1'b0, 28'h0000810, t);
    expect_cmd("after_rst_act", t + 1, R0, C_ACT, 3'd0, 14'd2,     1'b0, 1'b0, 1'b0);
    expect_cmd("after_rst_rd",  t + 5, R0, C_RD,  3'd0, 14'h0010, 1'b1, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
